// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM port responder with byte-enabled writes and optional wait states
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        resp_valid
);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              is_read;
  logic              unused_addr_bits;

  assign idx              = data_sram_addr[ADDR_W+1:2];
  assign is_read          = (data_sram_wen == 4'b0000);
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Writes commit at the accept edge; the array has no reset.
  always_ff @(posedge clk) begin
    if (accept && !is_read) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  if (WAIT_CYCLES == 0) begin : g_single
    assign accept   = rst & data_sram_en;
    assign stallreq = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_sram_rdata <= '0;
        resp_valid      <= 1'b0;
      end else begin
        resp_valid <= accept;
        if (accept && is_read) data_sram_rdata <= mem[idx];
      end
    end
  end else begin : g_wait
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] LOAD = 4'(WAIT_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  counter, counter_nx;
    logic [31:0] rd_latch;
    logic        rd_pend;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state           <= IDLE;
        counter         <= '0;
        rd_latch        <= '0;
        rd_pend         <= 1'b0;
        data_sram_rdata <= '0;
      end else begin
        state   <= state_nx;
        counter <= counter_nx;
        if (accept) begin
          rd_pend  <= is_read;
          rd_latch <= mem[idx];
        end
        if (state == BUSY && counter == 4'd1 && rd_pend) data_sram_rdata <= rd_latch;
      end
    end

    // DONE ignores en so the still-stalled requester is not accepted twice.
    always_comb begin
      state_nx   = state;
      counter_nx = counter;
      stallreq   = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      case (state)
        IDLE: begin
          stallreq = rst & data_sram_en;
          accept   = rst & data_sram_en;
          if (rst && data_sram_en) begin
            state_nx   = BUSY;
            counter_nx = LOAD;
          end
        end
        BUSY: begin
          stallreq   = 1'b1;
          counter_nx = counter - 4'd1;
          if (counter == 4'd1) state_nx = DONE;
        end
        DONE: begin
          resp_valid = 1'b1;
          state_nx   = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed self-checking bench for data_sram_responder
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        en0, en3, en2;
  logic [3:0]  wen0, wen3, wen2;
  logic [31:0] addr0, addr3, addr2;
  logic [31:0] wdata0, wdata3, wdata2;
  logic [31:0] rdata0, rdata3, rdata2;
  logic        stall0, stall3, stall2;
  logic        rv0, rv3, rv2;

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .stallreq(stall0), .resp_valid(rv0));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .stallreq(stall3), .resp_valid(rv3));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .data_sram_en(en2), .data_sram_wen(wen2),
    .data_sram_addr(addr2), .data_sram_wdata(wdata2), .data_sram_rdata(rdata2),
    .stallreq(stall2), .resp_valid(rv2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic d0(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en0 = e; wen0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic d3(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en3 = e; wen3 = w; addr3 = a; wdata3 = d;
  endtask

  task automatic d2(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en2 = e; wen2 = w; addr2 = a; wdata2 = d;
  endtask

  // Full WAIT=3 access with en held until DONE; exp is rdata expected in DONE.
  task automatic acc3(input string tag, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
    d3(1'b1, w, a, d);
    settle;
    chk({tag, "_issue_stall"}, stall3, 1);
    repeat (4) step;
    settle;
    chk({tag, "_done_rv"}, rv3, 1);
    chk({tag, "_done_stall"}, stall3, 0);
    chk({tag, "_done_rdata"}, rdata3, exp);
    step;
  endtask

  task automatic acc2(input string tag, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
    d2(1'b1, w, a, d);
    settle;
    chk({tag, "_issue_stall"}, stall2, 1);
    repeat (3) step;
    settle;
    chk({tag, "_done_rv"}, rv2, 1);
    chk({tag, "_done_stall"}, stall2, 0);
    chk({tag, "_done_rdata"}, rdata2, exp);
    step;
  endtask

  initial begin
    rst = 1'b0;
    d0(0, 4'h0, 32'h0, 32'h0);
    d3(0, 4'h0, 32'h0, 32'h0);
    d2(0, 4'h0, 32'h0, 32'h0);
    repeat (2) step;
    settle;
    chk("rst_rdata0", rdata0, 0);
    chk("rst_stall0", stall0, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rdata3", rdata3, 0);
    chk("rst_stall3", stall3, 0);
    chk("rst_rv3", rv3, 0);
    step;
    rst = 1'b1;
    step;

    // WAIT=0: full-word write then read
    d0(1, 4'hF, 32'h40, 32'hDEADBEEF);
    settle;
    chk("w0_wr_stall", stall0, 0);
    step;
    d0(1, 4'h0, 32'h40, 32'h0);
    settle;
    chk("w0_wr_rv", rv0, 1);
    chk("w0_wr_keeps_rdata", rdata0, 0);
    chk("w0_rd_stall", stall0, 0);
    step;
    d0(0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("w0_rd_rdata", rdata0, 32'hDEADBEEF);
    chk("w0_rd_rv", rv0, 1);
    chk("w0_rd_stall_after", stall0, 0);
    step;
    settle;
    chk("w0_idle_rv", rv0, 0);

    // Byte enables
    d0(1, 4'hF, 32'h80, 32'h11223344);
    step;
    d0(1, 4'b0101, 32'h80, 32'hAABBCCDD);
    step;
    d0(1, 4'h0, 32'h80, 32'h0);
    step;
    d0(0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("byte_en_merge", rdata0, 32'h11BB33DD);
    step;

    // Address aliasing
    d0(1, 4'hF, 32'h0000_1004, 32'hCAFEF00D);
    step;
    d0(1, 4'h0, 32'h0000_0004, 32'h0);
    step;
    d0(1, 4'h0, 32'h0000_0040, 32'h0);
    settle;
    chk("alias_1004_as_4", rdata0, 32'hCAFEF00D);
    step;
    d0(1, 4'h0, 32'h0000_0007, 32'h0);
    settle;
    chk("alias_other_word", rdata0, 32'hDEADBEEF);
    step;
    d0(0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("alias_unaligned_7", rdata0, 32'hCAFEF00D);
    step;

    // WAIT=3 read timing
    acc3("w3_pre", 4'hF, 32'h40, 32'h12345678, 32'h0);
    d3(1, 4'h0, 32'h40, 32'h0);
    settle;
    chk("w3_c0_stall", stall3, 1);
    chk("w3_c0_rv", rv3, 0);
    for (int c = 1; c <= 3; c++) begin
      step;
      settle;
      chk($sformatf("w3_c%0d_stall", c), stall3, 1);
      chk($sformatf("w3_c%0d_rv", c), rv3, 0);
    end
    chk("w3_c3_rdata_old", rdata3, 0);
    step;
    settle;
    chk("w3_c4_stall", stall3, 0);
    chk("w3_c4_rv", rv3, 1);
    chk("w3_c4_rdata", rdata3, 32'h12345678);
    step;
    d3(0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("w3_c5_no_reaccept", stall3, 0);
    chk("w3_c5_rv", rv3, 0);
    step;
    settle;
    chk("w3_c6_rv", rv3, 0);
    chk("w3_c6_rdata_hold", rdata3, 32'h12345678);

    // Reset mid-operation
    acc3("rst_pre_wr", 4'hF, 32'h44, 32'h11111111, 32'h12345678);
    acc3("rst_pre_rd", 4'h0, 32'h44, 32'h0, 32'h11111111);
    d3(1, 4'h0, 32'h40, 32'h0);
    step;
    step;
    settle;
    rst = 1'b0;
    #1;
    chk("midrst_stall", stall3, 0);
    chk("midrst_rdata", rdata3, 0);
    chk("midrst_rv", rv3, 0);
    step;
    step;
    d3(0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    settle;
    chk("postrst_stall", stall3, 0);
    chk("postrst_rv", rv3, 0);
    step;
    settle;
    chk("postrst_rv2", rv3, 0);
    chk("postrst_rdata", rdata3, 0);
    step;
    d3(1, 4'h0, 32'h40, 32'h0);
    settle;
    chk("fresh_c0_stall", stall3, 1);
    repeat (3) step;
    settle;
    chk("fresh_c3_rdata", rdata3, 0);
    step;
    settle;
    chk("fresh_c4_rdata", rdata3, 32'h12345678);
    chk("fresh_c4_rv", rv3, 1);
    step;
    d3(0, 4'h0, 32'h0, 32'h0);

    // WAIT=2 write then read at minimum spacing
    acc2("w2_prew", 4'hF, 32'h104, 32'h0F0F0F0F, 32'h0);
    acc2("w2_prer", 4'h0, 32'h104, 32'h0, 32'h0F0F0F0F);
    acc2("w2_wr", 4'hF, 32'h100, 32'h55AA55AA, 32'h0F0F0F0F);
    acc2("w2_rd", 4'h0, 32'h100, 32'h0, 32'h55AA55AA);
    d2(0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("w2_idle_stall", stall2, 0);
    chk("w2_idle_rv", rv2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
